// File: rtl/cpu6_memarb_if.sv
// Bus bundle for cpu6_memarb: fetch and data requester ports plus the shared memory port.
// slave is the arbiter's view of the bundle; master is the pipeline/memory side.
interface cpu6_memarb_if #(
  parameter int XLEN = 32
);
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic            if_kill;
  logic            if_done;
  logic [XLEN-1:0] if_rdata;

  logic            d_req;
  logic            d_we;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic            d_done;
  logic [XLEN-1:0] d_rdata;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ready;
  logic            mem_err;

  logic            stallF;
  logic            stallM;

  modport slave (
    input  if_req, if_addr, if_kill,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata, mem_ready,
    output if_done, if_rdata, d_done, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_err,
    output stallF, stallM
  );

  modport master (
    output if_req, if_addr, if_kill,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata, mem_ready,
    input  if_done, if_rdata, d_done, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_err,
    input  stallF, stallM
  );
endinterface

// File: rtl/cpu6_memarb.sv
// Single-port memory arbiter for cpu6: shares one memory port between fetch and MEM stage.
// Optional bus-timeout abort is enabled by defining CPU6_MEMARB_TIMEOUT_EN.
module cpu6_memarb #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input logic          clk,
  input logic          reset,
  cpu6_memarb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t          state;
  logic            lastData;
  logic            killed;
  logic            ifDone;
  logic            dDone;
  logic            memReq;
  logic            memWe;
  logic [XLEN-1:0] ifRdata;
  logic [XLEN-1:0] dRdata;
  logic [XLEN-1:0] memAddr;
  logic [XLEN-1:0] memWdata;

  logic            ifElig;
  logic            dElig;
  logic            grantData;
  logic            grantFetch;
  logic            tmoHit;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : gBadTimeout
    $error("cpu6_memarb: TIMEOUT must be in 1..255");
  end

  // A requester whose done is high this cycle is still holding its old request.
  assign ifElig     = bus.if_req & ~ifDone;
  assign dElig      = bus.d_req  & ~dDone;
  assign grantData  = dElig & (~ifElig | ~lastData);
  assign grantFetch = ifElig & ~grantData;

`ifdef CPU6_MEMARB_TIMEOUT_EN
  logic [7:0] tmoCount;
  logic       memErr;

  // Abort on the cycle the wait count would reach TIMEOUT; a same-cycle ready wins.
  assign tmoHit = (state != IDLE) && !bus.mem_ready
                  && (({1'b0, tmoCount} + 9'd1) == 9'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) begin
      tmoCount <= '0;
      memErr   <= 1'b0;
    end else begin
      memErr <= tmoHit;
      if (state == IDLE)
        tmoCount <= '0;
      else if (!bus.mem_ready)
        tmoCount <= tmoCount + 8'd1;
    end
  end

  assign bus.mem_err = memErr;
`else
  assign tmoHit      = 1'b0;
  assign bus.mem_err = 1'b0;
`endif

  // NOTE: all state below updates with non-blocking assignments so every register
  // samples pre-edge values; blocking here would make results depend on statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      lastData <= 1'b0;
      killed   <= 1'b0;
      ifDone   <= 1'b0;
      dDone    <= 1'b0;
      memReq   <= 1'b0;
      memWe    <= 1'b0;
      ifRdata  <= '0;
      dRdata   <= '0;
      memAddr  <= '0;
      memWdata <= '0;
    end else begin
      ifDone <= 1'b0;
      dDone  <= 1'b0;

      unique case (state)
        IDLE: begin
          killed <= 1'b0;
          if (grantData) begin
            state    <= BUSY_D;
            memReq   <= 1'b1;
            memWe    <= bus.d_we;
            memAddr  <= bus.d_addr;
            memWdata <= bus.d_wdata;
          end else if (grantFetch) begin
            state    <= BUSY_I;
            memReq   <= 1'b1;
            memWe    <= 1'b0;
            memAddr  <= bus.if_addr;
            memWdata <= '0;
          end
        end

        BUSY_I: begin
          if (bus.mem_ready || tmoHit) begin
            state    <= IDLE;
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
            lastData <= 1'b0;
            // A redirected fetch still finishes on the bus but is never delivered.
            if (!(killed || bus.if_kill)) begin
              ifDone  <= 1'b1;
              ifRdata <= bus.mem_ready ? bus.mem_rdata : '0;
            end
          end else if (bus.if_kill) begin
            killed <= 1'b1;
          end
        end

        BUSY_D: begin
          if (bus.mem_ready || tmoHit) begin
            state    <= IDLE;
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
            lastData <= 1'b1;
            dDone    <= 1'b1;
            if (tmoHit)
              dRdata <= '0;
            else if (!memWe)
              dRdata <= bus.mem_rdata;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.if_done   = ifDone;
  assign bus.if_rdata  = ifRdata;
  assign bus.d_done    = dDone;
  assign bus.d_rdata   = dRdata;
  assign bus.mem_req   = memReq;
  assign bus.mem_we    = memWe;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_wdata = memWdata;
  assign bus.stallF    = bus.if_req & ~ifDone;
  assign bus.stallM    = bus.d_req  & ~dDone;

endmodule
